// File: rtl/par2ser_en.sv
`default_nettype none
// ============================================================================
//  Module   : par2ser_en
//  Brief    : Parallel-to-serial feeder for an enable-gated D flip-flop.
//             Takes a DATA_W-bit word on a valid/ready handshake and emits it
//             LSB-first, one bit per enabled cycle, with downstream stall and
//             an optional idle gap after each word.
//  Revision : 1.0  initial release
// ============================================================================
module par2ser_en #(
  parameter int DATA_W     = 20,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              stall_i,
  output logic              d_o,
  output logic              en_o,
  output logic              last_o,
  output logic              busy_o
);

  // Bit counter spans 0..DATA_W-1.
  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  // Gap counter spans 0..GAP_CYCLES-1; kept one bit wide when unused.
  localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic              GAP_EN   = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  sreg;
  logic [CNT_W-1:0]   cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic               shifting;
  logic               at_last;
  logic               en;
  logic               last;
  logic               ready;
  logic               accept;
  logic               gap_done;

  // Handshake and strobe decode; ready stays low while reset is asserted.
  always_comb begin
    shifting = (state == ST_SHIFT);
    at_last  = (cnt == CNT_LAST);
    en       = shifting & ~stall_i;
    last     = en & at_last;
    ready    = reset & ((state == ST_IDLE) | (last & ~GAP_EN));
    accept   = valid_i & ready;
    gap_done = (state == ST_GAP) & (gap_cnt == GAP_LAST);
  end

  // Next-state logic: a word's last bit either opens the gap, chains the
  // next word with no bubble, or returns to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          if (GAP_EN) begin
            state_nxt = ST_GAP;
          end else if (accept) begin
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shift register and bit counter: load on accept, advance on each enabled
  // bit, hold through a stall. Counter wraps to zero after the last bit so it
  // never exceeds DATA_W-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= data_i;
      cnt  <= '0;
    end else if (en) begin
      sreg <= {1'b0, sreg[DATA_W-1:1]};
      cnt  <= at_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Gap counter: cleared on entry to the gap, counts while in it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (shifting & last & GAP_EN) begin
      gap_cnt <= '0;
    end else if (gap_done) begin
      gap_cnt <= '0;
    end else if (state == ST_GAP) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  // Serial outputs; data is forced low outside SHIFT.
  always_comb begin
    ready_o = ready;
    en_o    = en;
    last_o  = last;
    d_o     = shifting ? sreg[0] : 1'b0;
    busy_o  = (state != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_par2ser_en.sv
`default_nettype none
// ============================================================================
//  Module   : tb_par2ser_en
//  Brief    : Self-checking bench for par2ser_en. Two instances (gap 0 and
//             gap 2) share data/stall and have separate valids; each is
//             checked every cycle against a word/bit-index reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_par2ser_en;

  localparam int W = 20;

  logic          clk;
  logic          reset;
  logic [W-1:0]  data;
  logic          stall;
  logic          valid0, valid2;
  logic          ready0, ready2;
  logic          d0, d2, en0, en2, last0, last2, busy0, busy2;

  int checks;
  int errors;

  // Reference model state per instance (0: gap 0, 1: gap 2).
  logic          m_active [2];
  logic [W-1:0]  m_word   [2];
  int            m_sent   [2];
  int            m_gap    [2];
  int            m_gapc   [2];
  int            en0_count;

  par2ser_en #(.DATA_W(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .data_i(data), .valid_i(valid0), .ready_o(ready0),
    .stall_i(stall), .d_o(d0), .en_o(en0), .last_o(last0), .busy_o(busy0)
  );

  par2ser_en #(.DATA_W(W), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .data_i(data), .valid_i(valid2), .ready_o(ready2),
    .stall_i(stall), .d_o(d2), .en_o(en2), .last_o(last2), .busy_o(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] observed %0h expected %0h", tag, (k == 0) ? 0 : 2, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_word[k]   = '0;
      m_sent[k]   = 0;
      m_gap[k]    = 0;
    end
  endtask

  // One clock cycle: apply inputs just after a rising edge, compare on the
  // falling edge, then advance the model across the next rising edge.
  task automatic step(input logic v0, input logic v2, input logic [W-1:0] d, input logic s);
    logic e_en [2];
    logic e_last [2];
    logic e_rdy [2];
    logic vk;
    valid0 = v0;
    valid2 = v2;
    data   = d;
    stall  = s;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic e_d, e_busy;
      if (m_active[k]) begin
        e_d     = m_word[k][m_sent[k]];
        e_en[k] = ~s;
        e_last[k] = ~s && (m_sent[k] == W - 1);
        e_rdy[k]  = e_last[k] && (m_gapc[k] == 0);
        e_busy  = 1'b1;
      end else begin
        e_d       = 1'b0;
        e_en[k]   = 1'b0;
        e_last[k] = 1'b0;
        e_rdy[k]  = (m_gap[k] == 0);
        e_busy    = (m_gap[k] > 0);
      end
      chk("d_o",     k, {31'd0, (k == 0) ? d0     : d2},     {31'd0, e_d});
      chk("en_o",    k, {31'd0, (k == 0) ? en0    : en2},    {31'd0, e_en[k]});
      chk("last_o",  k, {31'd0, (k == 0) ? last0  : last2},  {31'd0, e_last[k]});
      chk("ready_o", k, {31'd0, (k == 0) ? ready0 : ready2}, {31'd0, e_rdy[k]});
      chk("busy_o",  k, {31'd0, (k == 0) ? busy0  : busy2},  {31'd0, e_busy});
    end
    if (en0) en0_count++;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      vk = (k == 0) ? v0 : v2;
      if (m_active[k] && e_en[k]) begin
        if (e_last[k]) begin
          m_active[k] = 1'b0;
          m_gap[k]    = m_gapc[k];
        end else begin
          m_sent[k]++;
        end
      end else if (!m_active[k] && m_gap[k] > 0) begin
        m_gap[k]--;
      end
      if (e_rdy[k] && vk) begin
        m_active[k] = 1'b1;
        m_word[k]   = d;
        m_sent[k]   = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom), 1'b0);
  endtask

  initial begin
    logic [W-1:0] rw;
    checks    = 0;
    errors    = 0;
    en0_count = 0;
    m_gapc[0] = 0;
    m_gapc[1] = 2;
    model_reset();
    reset  = 1'b0;
    valid0 = 1'b0;
    valid2 = 1'b0;
    data   = '0;
    stall  = 1'b0;

    // Reset state while reset is held low.
    #12;
    chk("rst_ready", 0, {31'd0, ready0}, 32'd0);
    chk("rst_ready", 1, {31'd0, ready2}, 32'd0);
    chk("rst_en",    0, {31'd0, en0},    32'd0);
    chk("rst_d",     0, {31'd0, d0},     32'd0);
    chk("rst_busy",  0, {31'd0, busy0},  32'd0);
    chk("rst_busy",  1, {31'd0, busy2},  32'd0);
    #8 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single word, no stall.
    step(1'b1, 1'b1, 20'h07C1F, 1'b0);
    idle(24);

    // Back-to-back on the gap-0 instance: 40 enabled cycles with no bubble.
    en0_count = 0;
    step(1'b1, 1'b0, 20'h07C1F, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 20'hFFFFF, 1'b0);
    idle(22);
    chk("b2b_en_count", 0, en0_count, 32'd40);

    // Stall three cycles while bit 5 is on the line.
    step(1'b1, 1'b1, 20'h07C1F, 1'b0);
    for (int i = 1; i <= 25; i++) step(1'b0, 1'b0, '0, (i >= 6 && i <= 8));
    idle(3);

    // Stall across the last bit on both instances.
    step(1'b1, 1'b1, 20'hA5A5A, 1'b0);
    for (int i = 1; i <= 26; i++) step(1'b0, 1'b0, '0, (i >= 20 && i <= 22));
    idle(3);

    // valid pulsed mid-word with different data must be ignored.
    step(1'b1, 1'b1, 20'h12345, 1'b0);
    for (int i = 1; i <= 24; i++) step((i == 7), (i == 7), 20'hFFFFF, 1'b0);
    idle(2);

    // Reset mid-word after bit 10, then restart cleanly.
    step(1'b1, 1'b1, 20'h3C3C3, 1'b0);
    for (int i = 1; i <= 11; i++) step(1'b0, 1'b0, '0, 1'b0);
    valid0 = 1'b0;
    valid2 = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_d",     0, {31'd0, d0},     32'd0);
    chk("midrst_en",    0, {31'd0, en0},    32'd0);
    chk("midrst_busy",  0, {31'd0, busy0},  32'd0);
    chk("midrst_ready", 0, {31'd0, ready0}, 32'd0);
    chk("midrst_busy",  1, {31'd0, busy2},  32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 20'h0F0F1, 1'b0);
    idle(24);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rw = W'($urandom);
      step(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4), rw,
           ($urandom_range(0, 9) < 2));
    end
    idle(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/par2ser_en.md
Name: par2ser_en

Overview:
- Parallel-to-serial feeder for the team's enable-gated D flip-flop stage.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits it LSB-first, one bit per enabled cycle.
- Drives d_o/en_o directly into the downstream flop's d_i/en_i.
- Supports a downstream stall and an optional programmable idle gap between words.

Parameters:
DATA_W, 20, word width in bits (>= 2)
GAP_CYCLES, 0, idle cycles inserted after each word's last bit (0 = back-to-back allowed)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release synchronous to clk
data_i  input  DATA_W  word to serialize; sampled only on accept
valid_i  input  1  upstream word valid
ready_o  output  1  block can accept a word this cycle
stall_i  input  1  downstream hold request; freezes shifting
d_o  output  1  serial data bit (to flop d_i)
en_o  output  1  bit-valid strobe (to flop en_i)
last_o  output  1  high with en_o on final bit of a word
busy_o  output  1  state is SHIFT or GAP

Behaviour:
- States:
  - IDLE: waiting for a word.
  - SHIFT: emitting bits.
  - GAP: counting out the inter-word gap; entered only if GAP_CYCLES > 0.
- Reset (reset low):
  - State IDLE; shift register, bit counter and gap counter cleared.
  - d_o=0, en_o=0, last_o=0, busy_o=0, ready_o=0 while reset is low.
  - A word in flight is discarded, with no partial completion.
- ready_o:
  - High in IDLE with reset high.
  - Also high in SHIFT on the last bit when en_o=1 and GAP_CYCLES=0.
  - Otherwise low.
  - Combinational from state/counter/stall_i.
- Accept occurs on a rising edge with valid_i=1 and ready_o=1:
  - Load shift register with data_i, clear the bit counter, go to SHIFT.
  - valid_i with ready_o=0 has no effect; data_i is ignored.
- SHIFT outputs:
  - d_o = shift register bit 0.
  - en_o = ~stall_i.
  - last_o = en_o & (bit count == DATA_W-1).
- Latency: the word accepted at edge N has bit 0 on d_o with en_o=1 in the cycle following edge N, unless stalled.
- Each edge with en_o=1: shift right by one and increment the bit count.
- Each edge with stall_i=1: shift register, count and d_o all hold.
- Transition on the edge where last_o=1:
  - GAP_CYCLES>0 → GAP, gap counter cleared.
  - Else if valid_i=1 → accept the new word and stay in SHIFT, giving a seamless bit stream.
  - Else → IDLE.
- GAP: d_o=0, en_o=0; after exactly GAP_CYCLES cycles in GAP → IDLE.
- IDLE and GAP: d_o=0, en_o=0, last_o=0; stall_i is ignored.
- Stall on the last bit: last_o and ready_o stay low until stall_i drops.
- Counter width is clog2(DATA_W); the count never exceeds DATA_W-1.

Test Plan:
- DATA_W=20, GAP=0, accept 20'h07C1F, no stall → d_o = 1×5, 0×5, 1×5, 0×5 over 20 consecutive en_o cycles; last_o only on the 20th; ready_o high in the 20th; IDLE afterwards, busy_o=0.
- Back-to-back: valid_i held with 20'h07C1F then 20'hFFFFF → 40 consecutive en_o=1 cycles with no bubble; second word accepted on the edge of the first word's last bit.
- Stall: stall_i high 3 cycles while bit 5 (value 0) is presented → en_o low 3 cycles, d_o holds 0, word completes after 23 cycles with the correct sequence.
- GAP_CYCLES=2 instance: after last_o, ready_o=0 and en_o=0 for exactly 2 cycles, then ready_o=1.
- Reset low mid-word (after bit 10) → d_o, en_o, busy_o and ready_o go 0 immediately; after release ready_o=1, and a new accept restarts at bit 0 with no residue.
- valid_i pulsed during SHIFT (GAP=0, not on last bit) → ignored, no corruption of the current word.
